// File: rtl/if_stage.sv
// if_stage: instruction fetch; assembles 32-bit little-endian words from an 8-bit
// synchronous memory port and hands them to decode with a valid/stall handshake.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_e,
    input  logic [31:0] br_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_is,
    output logic [31:0] if_ppc
);
    typedef enum logic [2:0] {B0, B1, B2, B3, WT, VLD} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_pc;
    logic [7:0]  r_b0, r_b1, r_b2;
    logic        r_pend;
    logic [1:0]  r_pidx;
    logic        w_fetch;

    // Byte states are encoded 0..3 so the low state bits double as the byte index.
    always_comb begin
        w_fetch  = (r_state == B0) || (r_state == B1) || (r_state == B2) || (r_state == B3);
        mem_req  = w_fetch;
        mem_addr = w_fetch ? r_pc + {30'd0, r_state[1:0]} : r_pc;
        w_next   = r_state;
        if (w_fetch && mem_gnt)
            w_next = state_t'(r_state + 3'd1);
        else if (r_state == WT)
            w_next = VLD;
        else if (r_state == VLD && !stall_i)
            w_next = B0;
        if (br_e)
            w_next = B0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= B0;
            r_pc     <= RESET_PC;
            r_pend   <= 1'b0;
            r_pidx   <= 2'd0;
            if_valid <= 1'b0;
            if_is    <= 32'h0;
            if_pc    <= 32'h0;
            if_ppc   <= 32'h0;
        end else begin
            if (r_pend && r_pidx == 2'd0) r_b0 <= mem_din;
            if (r_pend && r_pidx == 2'd1) r_b1 <= mem_din;
            if (r_pend && r_pidx == 2'd2) r_b2 <= mem_din;
            r_state <= w_next;
            r_pend  <= w_fetch && mem_gnt && !br_e;
            r_pidx  <= r_state[1:0];
            if (br_e) begin
                r_pc     <= {br_pc[31:2], 2'b00};
                if_valid <= 1'b0;
                if_is    <= 32'h0;
            end else if (r_state == WT) begin
                // The last byte is taken straight off the bus; it never lands in the buffer.
                if_is    <= {mem_din, r_b2, r_b1, r_b0};
                if_pc    <= r_pc;
                if_ppc   <= r_pc + 32'd4;
                if_valid <= 1'b1;
            end else if (r_state == VLD && !stall_i) begin
                r_pc     <= r_pc + 32'd4;
                if_valid <= 1'b0;
                if_is    <= 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed fetch scenarios with a byte-memory model and an expected-word
// scoreboard checked whenever decode sees a valid instruction.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        br_e = 1'b0;
    logic [31:0] br_pc = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b1;
    logic [7:0]  mem_din = 8'h0;
    logic        if_valid;
    logic [31:0] if_pc, if_is, if_ppc;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] is;
    } exp_t;
    exp_t q[$];

    if_stage dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .br_e(br_e), .br_pc(br_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_din(mem_din),
        .if_valid(if_valid), .if_pc(if_pc), .if_is(if_is), .if_ppc(if_ppc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ {a[1:0], 6'h15};
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {byte_at(pc + 32'd3), byte_at(pc + 32'd2), byte_at(pc + 32'd1), byte_at(pc)};
    endfunction

    // Memory returns data the cycle after an accepted request, junk otherwise.
    always @(posedge clk)
        mem_din <= (mem_req && mem_gnt) ? byte_at(mem_addr) : 8'hEE;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        q.push_back({pc, word_at(pc)});
    endtask

    task automatic wait_valid(input int budget);
        exp_t e;
        for (int i = 0; i < budget && !if_valid; i++) step();
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", q.size());
            return;
        end
        e = q.pop_front();
        if (!if_valid) begin
            total++;
            bad++;
            $error("FAIL valid_timeout observed=0 expected=1 pc=%h", e.pc);
            return;
        end
        chk("sb_pc", if_pc, e.pc);
        chk("sb_is", if_is, e.is);
        chk("sb_ppc", if_ppc, e.pc + 32'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_is", if_is, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_ppc", if_ppc, 32'h0);
        chk("rst_req", {31'd0, mem_req}, 32'd1);
        chk("rst_addr", mem_addr, 32'h0);
        rst = 1'b0;
        t0 = cyc;
        expect_fetch(32'h0);
        for (int k = 0; k < 4; k++) begin
            chk("f0_addr", mem_addr, k);
            chk("f0_req", {31'd0, mem_req}, 32'd1);
            step();
        end
        chk("wt_req", {31'd0, mem_req}, 32'd0);
        chk("wt_valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("f0_lat", cyc - t0, 32'd5);
        chk("f0_word", if_is, 32'h00100513);
        wait_valid(0);
        step();
        chk("cons_valid", {31'd0, if_valid}, 32'd0);
        chk("cons_is", if_is, 32'h0);
        chk("cons_pc_hold", if_pc, 32'h0);
        chk("next_addr", mem_addr, 32'h4);

        t0 = cyc;
        expect_fetch(32'h4);
        stall_i = 1'b1;
        wait_valid(20);
        chk("f4_lat", cyc - t0, 32'd5);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_is", if_is, word_at(32'h4));
            chk("stall_pc", if_pc, 32'h4);
            chk("stall_req", {31'd0, mem_req}, 32'd0);
        end
        stall_i = 1'b0;
        step();
        chk("unstall_valid", {31'd0, if_valid}, 32'd0);
        chk("unstall_addr", mem_addr, 32'h8);
        chk("ppc_hold", if_ppc, 32'h8);

        t0 = cyc;
        expect_fetch(32'h8);
        step();
        step();
        chk("b2_addr", mem_addr, 32'hA);
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("nogrant_addr", mem_addr, 32'hA);
            chk("nogrant_req", {31'd0, mem_req}, 32'd1);
            step();
        end
        mem_gnt = 1'b1;
        chk("regrant_addr", mem_addr, 32'hA);
        wait_valid(20);
        chk("f8_lat", cyc - t0, 32'd8);

        step();
        chk("f12_addr", mem_addr, 32'hC);
        repeat (3) step();
        chk("b3_addr", mem_addr, 32'hF);
        br_e = 1'b1;
        br_pc = 32'h0000_1002;
        step();
        br_e = 1'b0;
        chk("br_addr", mem_addr, 32'h1000);
        chk("br_valid", {31'd0, if_valid}, 32'd0);
        t0 = cyc;
        expect_fetch(32'h1000);
        wait_valid(20);
        chk("f1000_lat", cyc - t0, 32'd5);

        br_e = 1'b1;
        br_pc = 32'h200;
        step();
        br_e = 1'b0;
        chk("brcons_addr", mem_addr, 32'h200);
        chk("brcons_valid", {31'd0, if_valid}, 32'd0);
        chk("brcons_is", if_is, 32'h0);
        expect_fetch(32'h200);
        wait_valid(20);

        br_e = 1'b1;
        br_pc = 32'hFFFF_FFFF;
        step();
        br_e = 1'b0;
        expect_fetch(32'hFFFF_FFFC);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_addr", mem_addr, 32'hFFFF_FFFC + k);
            step();
        end
        wait_valid(20);
        chk("wrap_ppc", if_ppc, 32'h0);
        step();
        chk("wrap_next", mem_addr, 32'h0);
        step();
        step();
        chk("mid_addr", mem_addr, 32'h2);
        rst = 1'b1;
        step();
        chk("mrst_valid", {31'd0, if_valid}, 32'd0);
        chk("mrst_is", if_is, 32'h0);
        chk("mrst_pc", if_pc, 32'h0);
        chk("mrst_ppc", if_ppc, 32'h0);
        chk("mrst_addr", mem_addr, 32'h0);
        chk("mrst_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        t0 = cyc;
        expect_fetch(32'h0);
        wait_valid(20);
        chk("mrst_lat", cyc - t0, 32'd5);
        chk("sb_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
